// File: rtl/core_dmem_wb_responder.sv
// core_dmem_wb_responder: turns one MEM-stage load/store into one Wishbone B4 classic cycle.
// Optional ack timeout enabled by defining WB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module core_dmem_wb_responder #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       mem_addr_mem,
    input  logic [31:0]       mem_wdata_mem,
    input  logic              mem_write_mem,
    input  logic              mem_read_mem,
    input  logic [2:0]        mem_op_mem,
    output logic [31:0]       mem_rdata_mem,
    output logic              stall_pipl,
    output logic              misalign_err,
    output logic              bus_err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Reserved funct3 encodings (011, 110, 111) all land in the word case.
    function automatic size_e op_size(input logic [2:0] op);
        case (op[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic is_aligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return 1'b1;
            SZ_H:    return ~off[0];
            default: return (off == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input size_e sz, input logic [31:0] wdata);
        case (sz)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [31:0] word, input size_e sz,
                                                input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_B:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_H:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    size_e             size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;

    logic              req;
    size_e             req_size;
    logic [1:0]        req_off;
    logic              req_ok;
    logic              tmo_hit;

    assign req      = mem_read_mem | mem_write_mem;
    assign req_size = op_size(mem_op_mem);
    assign req_off  = mem_addr_mem[1:0];
    assign req_ok   = is_aligned(req_size, req_off);

`ifdef WB_TIMEOUT_EN
    localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMO_W    = (TMO_BITS < 8) ? 8 : TMO_BITS;

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts completed BUS cycles; any other state clears it so each access starts at zero.
    always_comb begin
        tmo_d = '0;
        if (state_q == S_BUS) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = (state_q == S_BUS) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Stall is combinational so the core freezes in the very cycle it presents the request.
    assign stall_pipl = reset_n &&
                        (((state_q == S_IDLE) && req && req_ok) || (state_q == S_BUS));

    always_comb begin
        // NOTE: every _d starts from its held value so no path can infer a latch.
        state_d    = state_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (req_ok) begin
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                        we_d    = mem_write_mem;
                        adr_d   = {mem_addr_mem[ADDR_W-1:2], 2'b00};
                        dat_d   = store_lanes(req_size, mem_wdata_mem);
                        sel_d   = lane_sel(req_size, req_off);
                        size_d  = req_size;
                        uns_d   = mem_op_mem[2];
                        off_d   = req_off;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            S_BUS: begin
                if (wb_err_i || wb_ack_i || tmo_hit) begin
                    state_d = S_DONE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                end
                if (wb_err_i) begin
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                end else if (wb_ack_i) begin
                    if (!we_q) begin
                        rdata_d = load_format(wb_dat_i, size_q, uns_q, off_q);
                    end
                end else if (tmo_hit) begin
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            size_q     <= SZ_W;
            uns_q      <= 1'b0;
            off_q      <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make every flop sample pre-edge values.
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = cyc_q;
    assign wb_we_o       = we_q;
    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;
    assign wb_sel_o      = sel_q;
    assign mem_rdata_mem = rdata_q;
    assign misalign_err  = misalign_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_core_dmem_wb_responder.sv
// Scoreboard bench for core_dmem_wb_responder: driver pushes expectations, negedge monitor pops and compares.
module tb_core_dmem_wb_responder;

    localparam int TMO     = 4;
    localparam int T_ACK   = 0;
    localparam int T_ERR   = 1;
    localparam int T_NONE  = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] mem_addr_mem, mem_wdata_mem, mem_rdata_mem;
    logic        mem_write_mem, mem_read_mem;
    logic [2:0]  mem_op_mem;
    logic        stall_pipl, misalign_err, bus_err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;

    always #5 clk = ~clk;

    core_dmem_wb_responder #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_addr_mem(mem_addr_mem), .mem_wdata_mem(mem_wdata_mem),
        .mem_write_mem(mem_write_mem), .mem_read_mem(mem_read_mem),
        .mem_op_mem(mem_op_mem), .mem_rdata_mem(mem_rdata_mem),
        .stall_pipl(stall_pipl), .misalign_err(misalign_err), .bus_err(bus_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
    } req_t;

    typedef struct {
        logic        misalign;
        logic        bus_err;
        logic [31:0] rdata;
        int          stalls;
    } rsp_t;

    req_t        bus_q[$];
    rsp_t        rsp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_rdata = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model (plain arithmetic on the access rules) ----------------
    function automatic int unsigned ref_size(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd4) return 1;
        if (op == 3'd1 || op == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit ref_aligned(input logic [2:0] op, input logic [31:0] addr);
        int unsigned a = addr;
        return (a % ref_size(op)) == 0;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [2:0] op, input logic [31:0] addr);
        int unsigned off = addr % 4;
        case (ref_size(op))
            1:       return 4'(1 << off);
            2:       return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdat(input logic [2:0] op, input logic [31:0] wdata);
        case (ref_size(op))
            1:       return (wdata % 32'd256) * 32'h0101_0101;
            2:       return (wdata % 32'd65536) * 32'h0001_0001;
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        int unsigned sz  = ref_size(op);
        int unsigned off = addr % 4;
        longint      x   = longint'(word >> (8 * off));
        longint      span = longint'(1) << (8 * sz);
        x = x % span;
        if (sz < 4 && (op == 3'd0 || op == 3'd1) && x >= span / 2) x = x - span;
        return 32'(x);
    endfunction

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_req();
        mem_read_mem  = 1'b0;
        mem_write_mem = 1'b0;
    endtask

    task automatic do_access(input bit wr, input bit rd, input logic [2:0] op,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int waits, input int term, input logic [31:0] rword,
                             input bit hold_done);
        req_t q;
        rsp_t r;
        mem_write_mem = wr;
        mem_read_mem  = rd;
        mem_op_mem    = op;
        mem_addr_mem  = addr;
        mem_wdata_mem = wdata;
        if (!ref_aligned(op, addr)) begin
            r = '{misalign: 1'b1, bus_err: 1'b0, rdata: exp_rdata, stalls: 0};
            rsp_q.push_back(r);
            step();
            drop_req();
            step();
            return;
        end
        q = '{adr: {addr[31:2], 2'b00}, sel: ref_sel(op, addr), we: wr, dat: ref_wdat(op, wdata)};
        bus_q.push_back(q);
        if (term != T_ACK)  exp_rdata = 32'd0;
        else if (!wr)       exp_rdata = ref_load(op, addr, rword);
        r = '{misalign: 1'b0, bus_err: (term != T_ACK), rdata: exp_rdata, stalls: 2 + waits};
        rsp_q.push_back(r);
        step();
        repeat (waits) begin
            wb_dat_i = $urandom;
            step();
        end
        wb_dat_i = rword;
        wb_ack_i = (term == T_ACK);
        wb_err_i = (term == T_ERR);
        step();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = $urandom;
        if (!hold_done) drop_req();
        step();
        drop_req();
        step();
    endtask

    // ---------------- monitor ----------------
    req_t cur = '{adr: 32'd0, sel: 4'd0, we: 1'b0, dat: 32'd0};
    bit   prev_cyc  = 1'b0;
    bit   post_evt  = 1'b0;
    int   stall_cnt = 0;

    always @(negedge clk) begin
        rsp_t r;
        if (!reset_n) begin
            prev_cyc  = 1'b0;
            post_evt  = 1'b0;
            stall_cnt = 0;
        end else begin
            if (post_evt) begin
                check("bus_err_pulse_end", {31'd0, bus_err}, 32'd0);
                check("misalign_pulse_end", {31'd0, misalign_err}, 32'd0);
                post_evt = 1'b0;
            end
            if (stall_pipl) stall_cnt++;
            if (wb_cyc_o) begin
                if (!prev_cyc) begin
                    check("cycle_expected", {31'd0, bus_q.size() > 0}, 32'd1);
                    if (bus_q.size() > 0) cur = bus_q.pop_front();
                end
                check("adr", wb_adr_o, cur.adr);
                check("sel", {28'd0, wb_sel_o}, {28'd0, cur.sel});
                check("we", {31'd0, wb_we_o}, {31'd0, cur.we});
                if (cur.we) check("dat_o", wb_dat_o, cur.dat);
                check("stb", {31'd0, wb_stb_o}, 32'd1);
                check("stall_in_bus", {31'd0, stall_pipl}, 32'd1);
            end else if (prev_cyc) begin
                check("rsp_expected", {31'd0, rsp_q.size() > 0}, 32'd1);
                if (rsp_q.size() > 0) begin
                    r = rsp_q.pop_front();
                    check("done_rdata", mem_rdata_mem, r.rdata);
                    check("done_bus_err", {31'd0, bus_err}, {31'd0, r.bus_err});
                    check("done_misalign", {31'd0, misalign_err}, {31'd0, r.misalign});
                    check("done_stall_low", {31'd0, stall_pipl}, 32'd0);
                    check("stall_cycles", 32'(stall_cnt), 32'(r.stalls));
                end
                stall_cnt = 0;
                post_evt  = 1'b1;
            end
            if (misalign_err) begin
                check("rsp_expected", {31'd0, rsp_q.size() > 0}, 32'd1);
                if (rsp_q.size() > 0) begin
                    r = rsp_q.pop_front();
                    check("misalign_kind", {31'd0, misalign_err}, {31'd0, r.misalign});
                    check("misalign_rdata", mem_rdata_mem, r.rdata);
                    check("misalign_no_cyc", {31'd0, wb_cyc_o}, 32'd0);
                    check("misalign_stalls", 32'(stall_cnt), 32'(r.stalls));
                end
                stall_cnt = 0;
                post_evt  = 1'b1;
            end
            prev_cyc = wb_cyc_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        drop_req();
        mem_op_mem = 3'd0; mem_addr_mem = 32'd0; mem_wdata_mem = 32'd0;
        wb_dat_i = 32'd0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        step();
        step();
        check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        check("rst_we", {31'd0, wb_we_o}, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        check("rst_rdata", mem_rdata_mem, 32'd0);
        check("rst_errs", {30'd0, misalign_err, bus_err}, 32'd0);
        check("rst_stall", {31'd0, stall_pipl}, 32'd0);
        reset_n = 1'b1;
        step();

        do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'd0, 0, T_ACK, 32'hDEAD_BEEF, 1'b0);
        do_access(1'b0, 1'b1, 3'b000, 32'h103, 32'd0, 0, T_ACK, 32'h80FF_0000, 1'b0);
        do_access(1'b0, 1'b1, 3'b100, 32'h103, 32'd0, 0, T_ACK, 32'h80FF_0000, 1'b0);
        do_access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0000_1234, 0, T_ACK, 32'h5555_AAAA, 1'b0);
        do_access(1'b0, 1'b1, 3'b001, 32'h101, 32'd0, 0, T_ACK, 32'd0, 1'b0);
        do_access(1'b0, 1'b1, 3'b010, 32'h104, 32'd0, 2, T_ERR, 32'h1234_5678, 1'b0);
        do_access(1'b0, 1'b1, 3'b101, 32'h306, 32'd0, 1, T_ACK, 32'hF00D_8001, 1'b1);
        do_access(1'b1, 1'b1, 3'b000, 32'h401, 32'h0000_00A5, 0, T_ACK, 32'hCAFE_F00D, 1'b0);
`ifdef WB_TIMEOUT_EN
        do_access(1'b0, 1'b1, 3'b010, 32'h500, 32'd0, TMO - 1, T_NONE, 32'h0, 1'b0);
`else
        do_access(1'b0, 1'b1, 3'b011, 32'h500, 32'd0, 20, T_ACK, 32'h7654_3210, 1'b0);
`endif

        // Reset while the slave is still stalling: no response, a late ack is ignored.
        mem_read_mem = 1'b1; mem_op_mem = 3'b010; mem_addr_mem = 32'h600;
        bus_q.push_back('{adr: 32'h600, sel: 4'hF, we: 1'b0, dat: 32'd0});
        step();
        step();
        reset_n = 1'b0;
        drop_req();
        step();
        check("rstmid_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("rstmid_stb", {31'd0, wb_stb_o}, 32'd0);
        check("rstmid_stall", {31'd0, stall_pipl}, 32'd0);
        check("rstmid_rdata", mem_rdata_mem, 32'd0);
        reset_n   = 1'b1;
        exp_rdata = 32'd0;
        wb_ack_i  = 1'b1;
        wb_dat_i  = 32'h1111_2222;
        step();
        wb_ack_i = 1'b0;
        step();
        check("late_ack_rdata", mem_rdata_mem, 32'd0);
        check("late_ack_cyc", {31'd0, wb_cyc_o}, 32'd0);

        for (int i = 0; i < 60; i++) begin
            bit          wr, rd, hold;
            logic [2:0]  op;
            logic [31:0] addr;
            int          term;
            wr   = 1'($urandom_range(0, 1));
            rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            hold = 1'($urandom_range(0, 1));
            op   = 3'($urandom_range(0, 7));
            addr = $urandom & 32'h0000_FFFF;
            term = ($urandom_range(0, 7) == 0) ? T_ERR : T_ACK;
            do_access(wr, rd, op, addr, $urandom, int'($urandom_range(0, 2)), term, $urandom, hold);
        end

        repeat (3) step();
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        check("bus_q_drained", 32'(bus_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/core_dmem_wb_responder.md
Name: core_dmem_wb_responder

Overview:
- Bus-side responder for the core's MEM-stage data port: accepts mem_addr/wdata/write/read/op and runs one Wishbone B4 classic cycle per access.
- Asserts stall_pipl back to the core until the access completes. Returns load data already byte-selected and sign/zero-extended per mem_op (RV32I funct3).
- Sits between the core top and the SoC Wishbone interconnect.

Parameters:
- ADDR_W, 32, Wishbone address width (byte address; wb_adr_o = {addr[ADDR_W-1:2],2'b00}).
- TIMEOUT_CYCLES, 255, ack wait limit; used only with WB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- mem_addr_mem  in  32  core byte address
- mem_wdata_mem  in  32  store data, LSB-aligned
- mem_write_mem  in  1  store request
- mem_read_mem  in  1  load request
- mem_op_mem  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_rdata_mem  out  32  formatted load data
- stall_pipl  out  1  hold core pipeline
- misalign_err  out  1  one-cycle pulse on misaligned access
- bus_err  out  1  one-cycle pulse on wb_err_i (or timeout)
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone master controls
- wb_adr_o  out  ADDR_W  word-aligned address
- wb_dat_o  out  32  lane-shifted store data
- wb_sel_o  out  4  byte lanes
- wb_dat_i  in  32  read data
- wb_ack_i, wb_err_i  in  1  termination

Behaviour:
- Reset (sync, reset_n=0 at clk edge): state IDLE, cyc/stb/we=0, adr/dat_o/sel=0, mem_rdata_mem=0, misalign_err=bus_err=0. Reset mid-cycle drops cyc/stb at that edge; no response is delivered.
- FSM IDLE -> BUS -> DONE -> IDLE.
- IDLE, request = read|write. If both are set, the access is a write.
  - Request aligned: stall_pipl=1 combinationally in the same cycle. Latch addr/op/we/data; next cycle is BUS with cyc=stb=1.
  - Alignment rules: H/HU need addr[0]=0; W needs addr[1:0]=0.
  - Request misaligned: no bus cycle, stall_pipl=0, misalign_err=1 next cycle, mem_rdata_mem unchanged.
  - Reserved op (011, 110, 111): treated as W.
- BUS: cyc/stb/we/adr/sel/dat_o held stable; stall_pipl=1.
  - On wb_ack_i: capture formatted data into mem_rdata_mem, drop cyc/stb at that edge, go to DONE.
  - On wb_err_i (priority over ack): mem_rdata_mem=0, bus_err=1 next cycle, go to DONE.
- DONE: stall_pipl=0 for exactly one cycle so the core advances; the request is ignored this cycle to prevent reissue. Then IDLE.
- Minimum latency: a zero-wait slave acks in the first BUS cycle, giving 2 stall cycles per access (IDLE request cycle + BUS).
- sel: B = 4'b0001 << addr[1:0]; H = 4'b0011 << {addr[1],1'b0}; W = 4'b1111.
- dat_o: B replicates wdata[7:0] to all lanes; H replicates wdata[15:0]; W passes wdata through.
- Load format: select the lane by addr[1:0], then extend.
  - B and H sign-extend; BU and HU zero-extend.
  - Writes leave mem_rdata_mem unchanged.
- mem_rdata_mem holds its value until the next completed read.

Optional Feature:
- WB_TIMEOUT_EN defined:
  - An 8+-bit counter (width $clog2(TIMEOUT_CYCLES+1)) runs in BUS and clears on entry.
  - When it reaches TIMEOUT_CYCLES without ack or err: abort (cyc/stb=0), mem_rdata_mem=0, bus_err pulse, go to DONE.
- Not defined: no counter; BUS waits indefinitely.

Test Plan:
- LW addr 0x100, slave acks first BUS cycle with 0xDEADBEEF -> stall high 2 cycles, then low. mem_rdata=0xDEADBEEF, sel=4'hF, adr=0x100.
- LB addr 0x103, dat_i 0x80FF_0000 -> sel=4'b1000, mem_rdata=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH addr 0x202, wdata 0x0000_1234 -> we=1, sel=4'b1100, dat_o=0x12341234, adr=0x200; mem_rdata unchanged.
- LH addr 0x101 -> no cyc, stall never high, misalign_err pulse 1 cycle. LW with wb_err_i on 3rd wait cycle -> mem_rdata=0, bus_err pulse, stall drops after DONE.
- reset_n low while in BUS with ack pending -> next edge cyc=stb=0, stall=0, mem_rdata=0. A later ack is ignored.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks -> cyc drops after 4 BUS cycles, bus_err pulse, core released.
